// File: rtl/feature_bank_reader.sv
// Read sequencer: streams every row of the feature bank, in address order, to the
// clause engine over valid/ready. SPI writes to the bank pause issue; a 3-entry skid FIFO absorbs backpressure.
module feature_bank_reader #(
  parameter  int N_MEL   = 32,
  parameter  int N_FRAME = 64,
  localparam int ROWS    = 2 * N_MEL,
  localparam int AW      = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               spi_wen_fe_bank_sync,
  output logic               feature_bank_ren,
  output logic [AW-1:0]      feature_rptr,
  input  logic [N_FRAME-1:0] feature_bank_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_FRAME-1:0] out_data,
  output logic [AW-1:0]      out_row,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic [AW-1:0]      row;
    logic [N_FRAME-1:0] data;
  } entry_t;

  state_t        state;
  logic          inflight;
  logic [AW-1:0] row_q;
  entry_t        mem [3];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [1:0]    count;
  logic [2:0]    credit;
  logic          push;
  logic          pop;
  entry_t        head;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit covers both stored rows and the read still in the bank pipeline,
  // so issue never depends on out_ready and the FIFO cannot overflow.
  assign credit           = {1'b0, count} + {2'b00, inflight};
  assign feature_bank_ren = (state == ISSUE) && !spi_wen_fe_bank_sync && (credit < 3'd3);

  assign push      = inflight;
  assign head      = mem[rd_ptr];
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = head.data;
  assign out_row   = head.row;
  assign out_last  = out_valid && (head.row == AW'(ROWS - 1));

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      feature_rptr <= '0;
      inflight     <= 1'b0;
      row_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= feature_bank_ren;
      if (feature_bank_ren) row_q <= feature_rptr;
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= ISSUE;
            feature_rptr <= '0;
            busy         <= 1'b1;
          end
        end
        ISSUE: begin
          if (feature_bank_ren) begin
            feature_rptr <= feature_rptr + AW'(1);
            if (feature_rptr == AW'(ROWS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the skid storage is reset as well, because out_data/out_row are driven
  // straight from the head entry and must read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{row: row_q, data: feature_bank_rdata};
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_bank_reader.sv
// Self-checking bench for feature_bank_reader: bank model plus a row-level
// scoreboard predicting issue, delivery order, latency, busy and done.
module tb_feature_bank_reader;

  localparam int N_MEL   = 32;
  localparam int N_FRAME = 64;
  localparam int ROWS    = 2 * N_MEL;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               spi_wen_fe_bank_sync;
  logic               feature_bank_ren;
  logic [5:0]         feature_rptr;
  logic [N_FRAME-1:0] feature_bank_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [N_FRAME-1:0] out_data;
  logic [5:0]         out_row;
  logic               out_last;
  logic               busy;
  logic               done;

  logic [N_FRAME-1:0] bank [ROWS];
  int errors = 0;
  int checks = 0;

  feature_bank_reader #(.N_MEL(N_MEL), .N_FRAME(N_FRAME)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .spi_wen_fe_bank_sync (spi_wen_fe_bank_sync),
    .feature_bank_ren     (feature_bank_ren),
    .feature_rptr         (feature_rptr),
    .feature_bank_rdata   (feature_bank_rdata),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_row              (out_row),
    .out_last             (out_last),
    .busy                 (busy),
    .done                 (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank with a registered read port: data appears the cycle after ren.
  always @(posedge clk) begin
    if (feature_bank_ren) feature_bank_rdata <= bank[feature_rptr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ren"},   feature_bank_ren, 0);
    check({tag, "_rptr"},  feature_rptr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"},  out_data, 0);
    check({tag, "_row"},   out_row, 0);
    check({tag, "_last"},  out_last, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
  endtask

  // One full pass. Cycle c is the period after edge c; start is sampled at edge 0.
  // exact: fixed-latency timeline checks (requires no backpressure or SPI).
  task automatic run_pass(input bit exact, input int rlo, input int rhi, input int slo,
                          input int shi, input bit rnd, input int repulse,
                          input bit chain, input int abort_row);
    int  issued = 0, popped = 0, iss_prev = 0, dones = 0, spi_left = 0, cur;
    bit  done_next = 0, finished = 0, exp_ren;
    for (int i = 0; i < ROWS; i++) bank[i] = {$urandom, $urandom};
    start = 1'b1;
    out_ready = 1'b1;
    spi_wen_fe_bank_sync = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 1500 && !finished; c++) begin
      #1;
      start = (c == repulse) || (chain && c == 67);
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
        if (spi_left > 0) begin
          spi_wen_fe_bank_sync = 1'b1;
          spi_left--;
        end else if ($urandom_range(0, 7) == 0) begin
          spi_wen_fe_bank_sync = 1'b1;
          spi_left = $urandom_range(0, 3);
        end else begin
          spi_wen_fe_bank_sync = 1'b0;
        end
      end else begin
        out_ready = !(c >= rlo && c <= rhi);
        spi_wen_fe_bank_sync = (c >= slo && c <= shi);
      end
      @(negedge clk);
      cur = issued;
      exp_ren = (issued < ROWS) && !spi_wen_fe_bank_sync && (issued - popped < 3);
      check("rptr", feature_rptr, 64'(issued % ROWS));
      check("ren", feature_bank_ren, exp_ren);
      check("valid", out_valid, iss_prev > popped);
      check("busy", busy, popped < ROWS);
      check("done", done, done_next);
      if (exact) begin
        check("t_ren", feature_bank_ren, c <= 64);
        check("t_valid", out_valid, c >= 3 && c <= 66);
        check("t_last", out_last, c == 66);
        check("t_busy", busy, c <= 66);
        check("t_done", done, c == 67);
      end
      if (out_valid) begin
        check("row", out_row, 64'(popped));
        check("data", out_data, bank[popped % ROWS]);
        check("last", out_last, popped == ROWS - 1);
      end
      done_next = 1'b0;
      if (done) begin
        dones++;
        finished = 1'b1;
      end
      if (out_valid && out_ready) begin
        popped++;
        if (popped == ROWS) done_next = 1'b1;
      end
      iss_prev = cur;
      if (feature_bank_ren) issued++;
      if (abort_row >= 0 && popped == abort_row) begin
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        start = 1'b0;
        out_ready = 1'b1;
        spi_wen_fe_bank_sync = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      if (!finished) @(posedge clk);
    end
    check("beats", popped, ROWS);
    check("issued", issued, ROWS);
    check("done_count", dones, 1);
    if (!chain) begin
      @(posedge clk);
      #1 start = 1'b0;
      out_ready = 1'b1;
      spi_wen_fe_bank_sync = 1'b0;
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_valid", out_valid, 0);
      check("idle_busy", busy, 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    spi_wen_fe_bank_sync = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Baseline timeline with an ignored restart at cycle 20 and a restart in the done cycle.
    run_pass(1, -1, -1, -1, -1, 0, 20, 1, -1);
    // Chained second pass must begin again at row 0 with identical timing.
    run_pass(1, -1, -1, -1, -1, 0, -1, 0, -1);
    // Backpressure window.
    run_pass(0, 6, 15, -1, -1, 0, -1, 0, -1);
    // SPI inhibit window.
    run_pass(0, -1, -1, 10, 13, 0, -1, 0, -1);
    // Reset while row 20 is at the head, then a clean pass from row 0.
    run_pass(0, -1, -1, -1, -1, 0, -1, 0, 20);
    run_pass(1, -1, -1, -1, -1, 0, -1, 0, -1);
    // Random backpressure and SPI inhibit.
    for (int p = 0; p < 20; p++) run_pass(0, -1, -1, -1, -1, 1, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/feature_bank_reader.md
Name: feature_bank_reader

Overview:
- Accelerator-side read sequencer for the feature bank.
- On `start`, it walks all 2*N_MEL rows of the feature bank in address order using the bank's read port (`feature_bank_ren`, `feature_rptr`, `feature_bank_rdata`). The bank has 1-cycle read latency.
- Each N_FRAME-bit row is delivered to the Tsetlin clause engine over a valid/ready stream.
- A 3-entry skid FIFO absorbs backpressure. Reads are suspended while an SPI write to the bank is in progress, because SPI has address priority at the bank.

Parameters:
- N_MEL, 32, number of mel bands; row count is 2*N_MEL.
- N_FRAME, 64, row width in bits (frames per row).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to stream the whole bank; accepted only in IDLE.
- spi_wen_fe_bank_sync  in  1  SPI write to the bank in progress; inhibits reads.
- feature_bank_ren  out  1  bank read enable, active-high.
- feature_rptr  out  $clog2(2*N_MEL)  bank row address.
- feature_bank_rdata  in  N_FRAME  bank read data; valid in the cycle after `feature_bank_ren`.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  N_FRAME  row contents.
- out_row  out  $clog2(2*N_MEL)  row index of `out_data`.
- out_last  out  1  high with row 2*N_MEL-1.
- busy  out  1  high from accepted `start` until the final row handshakes.
- done  out  1  one-cycle pulse, asserted the cycle after the final handshake.

Behaviour:
- Reset: all state clears asynchronously.
  - FSM goes to IDLE.
  - `feature_rptr`, issue counter, FIFO pointers and count, and the in-flight flag go to 0.
  - Every output is 0: `feature_bank_ren`, `feature_rptr`, `out_valid`, `out_data`, `out_row`, `out_last`, `busy`, `done`.
- Reset mid-stream: all progress is discarded; the next `start` begins again at row 0.
- FSM states:
  - IDLE -> ISSUE on `start`. The issue counter is cleared to 0 and `busy` goes high on the next cycle.
  - ISSUE -> DRAIN when row 2*N_MEL-1 has been issued.
  - DRAIN -> IDLE when the `out_last` beat handshakes (`out_valid` && `out_ready` && `out_last`). `done` is registered high for exactly 1 cycle, during which the FSM is already in IDLE.
  - `start` in any state other than IDLE is ignored. `start` during the `done` cycle is accepted.
- Read issue:
  - `feature_bank_ren` = (state==ISSUE) && !spi_wen_fe_bank_sync && (fifo_count + inflight < 3).
  - `feature_rptr` = issue counter; it increments on each issued read.
  - `inflight` is a register equal to the previous cycle's `feature_bank_ren`.
  - There is no combinational path from `out_ready` to `feature_bank_ren`.
- Capture: when `inflight` = 1, `feature_bank_rdata` is pushed into the FIFO together with its row index (a delayed copy of `feature_rptr`). The credit check guarantees the FIFO never overflows.
- SPI collision: while `spi_wen_fe_bank_sync` = 1, no read is issued and `feature_rptr` holds. A read issued in the cycle before SPI asserts still returns valid data, since the bank output is registered.
- Output stream:
  - `out_valid` = FIFO not empty. `out_data`, `out_row` and `out_last` come from the FIFO head.
  - A pop occurs on `out_valid` && `out_ready`.
  - Once `out_valid` is asserted, the head must hold stable until it handshakes.
  - Push and pop in the same cycle leave the count unchanged.
- Latency and throughput:
  - With `start` at edge 0, `feature_bank_ren` is first high in cycle 1 and `out_valid` is first high in cycle 3.
  - With `out_ready` tied high, throughput is 1 row per cycle: 2*N_MEL consecutive beats.
- Ordering: rows are delivered strictly 0..2*N_MEL-1, each exactly once, under any pattern of backpressure or SPI inhibit.

Test Plan:
- `out_ready`=1, `start` pulse at cycle 0 -> `feature_bank_ren` high cycles 1..64; `out_valid` cycles 3..66 with `out_row` 0..63 and `out_data` matching preloaded bank contents; `out_last` at cycle 66; `done` pulse at cycle 67; `busy` cycles 1..66.
- `out_ready` low cycles 6..15 -> `feature_bank_ren` drops once count+inflight=3; FIFO holds 3 rows; resume with no gaps, duplicates or loss; all 64 rows delivered in order.
- `spi_wen_fe_bank_sync` high cycles 10..13 -> `feature_bank_ren`=0 and `feature_rptr` frozen during those cycles; delivered data still matches rows 0..63 in order.
- `start` re-pulsed at cycle 20 while busy -> ignored, exactly 64 beats and one `done`. `start` pulsed during the `done` cycle -> second full pass starting at row 0.
- `rst_n` low during row 20 -> all outputs 0 immediately (asynchronous); after release and a new `start` -> row 0 is the first beat.
- Random `out_ready` (50% duty) plus random SPI inhibit over 20 passes -> scoreboard match on every row, FIFO count never exceeds 3.
